ej32_rs_branch: RTL and testbench
=================================

// Module: ej32_rs_branch
// PURPOSE
//  Parametrised successor to the eJ32 branching unit: owns a return stack of DEPTH entries and its own phase FSM.
//  Sits beside the decoder: decoder issues a branch/RS op plus bytecode operand bytes;
//  block returns jump target + select, TOS write-back, stack occupancy and sticky error flags.
// PARAMETERS
//  DEPTH  32  return-stack entries; power of 2, >=4; RPW=$clog2(DEPTH) derived, count is RPW+1 bits
//  DSZ    32  data / stack-entry width
//  ASZ    17  instruction address width (<=DSZ)
// PORTS
//  clk      in   1      clock
//  rst      in   1      asynchronous, active-low reset
//  br_en    in   1      unit enable; 0 = freeze all state
//  op_vld   in   1      op request
//  op       in   4      0 NOP,1 GOTO,2 IFZ,3 IFNZ,4 IFLT,5 IFGE,6 IFGT,7 IFLE,8 CALL,9 RET,10 NEXT,11 PUSHR,12 POPR,13 DUPR,14 RLOAD,15 RSTORE
//  p        in   ASZ    current instruction pointer
//  data     in   8      operand byte from memory bus
//  t        in   DSZ    data-stack TOS
//  idx      in   RPW    entry index for RLOAD/RSTORE, 0 = top
//  err_clr  in   1      clear sticky flags
//  busy     out  1      op in progress; new op_vld ignored
//  done     out  1      1-cycle pulse, op complete
//  br_p_o   out  ASZ    jump target
//  br_psel  out  1      1-cycle pulse: take br_p_o
//  t_o      out  DSZ    TOS write-back value
//  t_we     out  1      1-cycle pulse: write t_o to TOS
//  rs_cnt   out  RPW+1  stack occupancy
//  ovf/unf  out  1      sticky overflow / underflow
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, rs_cnt 0, stack contents don't-care; takes effect immediately, aborts any op.
//  FSM IDLE->HI->LO (GOTO/IF*/CALL/NEXT) | IDLE->RD (RET/POPR/RLOAD) | IDLE->IDLE (DUPR/PUSHR/RSTORE/NOP).
//  Accept: op_vld&&!busy&&br_en in IDLE; op, p, t, idx latched at accept; busy high from next cycle until return to IDLE.
//  Branch ops: data at accept = target high byte, data in following (LO) cycle = low byte.
//   Target = {hi,lo} zero-extended/truncated to ASZ.
//  Outputs registered: done/br_psel/t_we rise the cycle after the final FSM cycle, held exactly 1 cycle.
//  Latency accept->done: branch 2 cycles, RD ops 2, single ops 1.
//  IF* tests latched t: Z t==0, LT t[DSZ-1], GE !LT, GT !Z&&!LT, LE Z||LT; false -> done without br_psel.
//  CALL: push zero-extended p+2 (ASZ wrap), jump. RET: jump to top[ASZ-1:0], pop.
//  NEXT: top==0 -> pop, no jump; else top<=top-1, jump.
//  PUSHR push t; POPR t_o=top,t_we,pop; DUPR t_o=top,t_we; RLOAD t_o=entry[idx],t_we; RSTORE entry[idx]<=t.
//  Top entry held in a register; storage below may be sync-read RAM (1-cycle latency, read refill in RD).
//  Full (rs_cnt==DEPTH) push: ovf<=1, handling per CONFIGURATION. Empty pop/read (RET,POPR,DUPR,NEXT):
//   unf<=1, no jump, no t_we, rs_cnt stays 0, done still pulses.
//  RLOAD/RSTORE with idx>=rs_cnt: unf<=1, RLOAD t_we with t_o=0, RSTORE no write.
//  err_clr clears ovf/unf; new error same cycle wins (flag set).
//  br_en=0: FSM, stack, flags frozen; pulse outputs forced 0; resumes in same state (LO byte sampled on resume).
//  op_vld while busy: dropped, no queue; decoder must re-issue.
// CONFIGURATION
//  EJ32_RS_WRAP_EN defined: stack circular; push at full overwrites oldest entry, rs_cnt stays DEPTH, ovf still set.
//  Undefined: push at full dropped, stack and rs_cnt unchanged, ovf set.
// TESTING
//  Reset; CALL p=0x00100, data 0x01,0x23 -> br_p_o=0x00123, br_psel 1 cycle, rs_cnt=1; RET -> br_p_o=0x00102, rs_cnt=0.
//  IFZ t=0, data 0x00,0x40 -> br_psel=1, br_p_o=0x00040; IFZ t=5 -> done=1, br_psel=0.
//  PUSHR t=2; NEXT 0x00,0x40 x3 -> jumps with top 1,0 then pop without jump; rs_cnt=0.
//  DEPTH=32, PUSHR 1..33 -> ovf=1, rs_cnt=32; no macro: POPR t_o=32; WRAP_EN: t_o=33, RLOAD idx31 t_o=2.
//  POPR on empty -> unf=1, t_we=0, done=1; err_clr -> unf=0.
//  rst low during LO of GOTO -> busy,br_psel,rs_cnt=0 without clock edge; br_en=0 mid-op holds busy, no done.

Source files
------------

// File: rtl/ej32_rs_branch_if.sv
// ej32_rs_branch_if: decoder <-> branching unit bus.
// The decoder side (master) issues ops, operand bytes and stack indices;
// the unit side (slave) returns jump/TOS write-back pulses, stack occupancy and error flags.
interface ej32_rs_branch_if #(
    parameter int DEPTH = 32,
    parameter int DSZ   = 32,
    parameter int ASZ   = 17
);
    localparam int RPW = $clog2(DEPTH);

    logic           br_en;
    logic           op_vld;
    logic [3:0]     op;
    logic [ASZ-1:0] p;
    logic [7:0]     data;
    logic [DSZ-1:0] t;
    logic [RPW-1:0] idx;
    logic           err_clr;
    logic           busy;
    logic           done;
    logic [ASZ-1:0] br_p_o;
    logic           br_psel;
    logic [DSZ-1:0] t_o;
    logic           t_we;
    logic [RPW:0]   rs_cnt;
    logic           ovf;
    logic           unf;

    modport master (
        output br_en, op_vld, op, p, data, t, idx, err_clr,
        input  busy, done, br_p_o, br_psel, t_o, t_we, rs_cnt, ovf, unf
    );

    modport slave (
        input  br_en, op_vld, op, p, data, t, idx, err_clr,
        output busy, done, br_p_o, br_psel, t_o, t_we, rs_cnt, ovf, unf
    );
endinterface

// File: rtl/ej32_rs_branch.sv
// ej32_rs_branch: eJ32 branching unit with a private return stack and phase FSM.
// Stack is a circular buffer addressed by a write pointer; the top entry sits just below it.
// Build macro EJ32_RS_WRAP_EN: a push at full overwrites the oldest entry
// (rs_cnt stays at DEPTH); without it the push is dropped. Both cases raise ovf.
module ej32_rs_branch #(
    parameter int DEPTH = 32,
    parameter int DSZ   = 32,
    parameter int ASZ   = 17
) (
    input  logic            clk,
    input  logic            rst,
    ej32_rs_branch_if.slave bus
);
    localparam int RPW = $clog2(DEPTH);
    localparam logic [RPW:0] FULL_CNT = (RPW+1)'(DEPTH);
`ifdef EJ32_RS_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef enum logic [3:0] {
        OP_NOP, OP_GOTO, OP_IFZ, OP_IFNZ, OP_IFLT, OP_IFGE, OP_IFGT, OP_IFLE,
        OP_CALL, OP_RET, OP_NEXT, OP_PUSHR, OP_POPR, OP_DUPR, OP_RLOAD, OP_RSTORE
    } op_e;

    // The accept cycle is the high-byte phase; S_LO samples the low byte.
    typedef enum logic [1:0] {S_IDLE, S_LO, S_RD} state_e;

    state_e         state_q, state_d;
    op_e            op_in, op_q;
    logic [ASZ-1:0] p_q;
    logic [DSZ-1:0] t_q;
    logic [RPW-1:0] idx_q;
    logic [7:0]     hi_q;
    logic [DSZ-1:0] mem [DEPTH];
    logic [RPW-1:0] wp_q, wp_d;
    logic [RPW:0]   cnt_q, cnt_d;
    logic           ovf_q, ovf_d, unf_q, unf_d;
    logic           done_q, done_d, psel_q, psel_d, twe_q, twe_d;
    logic [ASZ-1:0] tgt_q, tgt_d;
    logic [DSZ-1:0] to_q, to_d;
    logic           accept, empty, full, is_z, is_lt, cond;
    logic [RPW-1:0] top_addr, idx_addr, in_idx_addr, wr_addr;
    logic [DSZ-1:0] top, idx_entry, push_val, wr_val;
    logic [ASZ-1:0] tgt_w;
    logic           push, pop, wr_en, set_ovf, set_unf;

    assign op_in       = op_e'(bus.op);
    assign accept      = (state_q == S_IDLE) && bus.op_vld && bus.br_en;
    assign empty       = (cnt_q == '0);
    assign full        = (cnt_q == FULL_CNT);
    assign top_addr    = wp_q - RPW'(1);
    assign idx_addr    = top_addr - idx_q;
    assign in_idx_addr = top_addr - bus.idx;
    assign top         = mem[top_addr];
    assign idx_entry   = mem[idx_addr];
    assign tgt_w       = ASZ'({hi_q, bus.data});
    assign is_z        = (t_q == '0);
    assign is_lt       = t_q[DSZ-1];

    // Branch condition for the latched op; unconditional ops always take.
    always_comb begin
        cond = 1'b1;
        case (op_q)
            OP_IFZ:  cond = is_z;
            OP_IFNZ: cond = !is_z;
            OP_IFLT: cond = is_lt;
            OP_IFGE: cond = !is_lt;
            OP_IFGT: cond = !is_z && !is_lt;
            OP_IFLE: cond = is_z || is_lt;
            default: cond = 1'b1;
        endcase
    end

    // Next state, registered-output values and stack actions for each phase.
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        psel_d   = 1'b0;
        twe_d    = 1'b0;
        tgt_d    = tgt_q;
        to_d     = to_q;
        push     = 1'b0;
        push_val = '0;
        pop      = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = top_addr;
        wr_val   = '0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.op_vld) begin
                    case (op_in)
                        OP_GOTO, OP_IFZ, OP_IFNZ, OP_IFLT, OP_IFGE, OP_IFGT, OP_IFLE,
                        OP_CALL, OP_NEXT: state_d = S_LO;
                        OP_RET, OP_POPR, OP_RLOAD: state_d = S_RD;
                        OP_PUSHR: begin
                            done_d   = 1'b1;
                            push     = 1'b1;
                            push_val = bus.t;
                        end
                        OP_DUPR: begin
                            done_d = 1'b1;
                            if (empty) begin
                                set_unf = 1'b1;
                            end else begin
                                twe_d = 1'b1;
                                to_d  = top;
                            end
                        end
                        OP_RSTORE: begin
                            done_d = 1'b1;
                            if ({1'b0, bus.idx} < cnt_q) begin
                                wr_en   = 1'b1;
                                wr_addr = in_idx_addr;
                                wr_val  = bus.t;
                            end else begin
                                set_unf = 1'b1;
                            end
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            S_LO: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                case (op_q)
                    OP_CALL: begin
                        push     = 1'b1;
                        push_val = DSZ'(p_q + ASZ'(2));
                        psel_d   = 1'b1;
                        tgt_d    = tgt_w;
                    end
                    OP_NEXT: begin
                        if (empty) begin
                            set_unf = 1'b1;
                        end else if (top == '0) begin
                            pop = 1'b1;
                        end else begin
                            wr_en  = 1'b1;
                            wr_val = top - DSZ'(1);
                            psel_d = 1'b1;
                            tgt_d  = tgt_w;
                        end
                    end
                    default: begin
                        if (cond) begin
                            psel_d = 1'b1;
                            tgt_d  = tgt_w;
                        end
                    end
                endcase
            end
            S_RD: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                case (op_q)
                    OP_RET: begin
                        if (empty) begin
                            set_unf = 1'b1;
                        end else begin
                            psel_d = 1'b1;
                            tgt_d  = top[ASZ-1:0];
                            pop    = 1'b1;
                        end
                    end
                    OP_POPR: begin
                        if (empty) begin
                            set_unf = 1'b1;
                        end else begin
                            twe_d = 1'b1;
                            to_d  = top;
                            pop   = 1'b1;
                        end
                    end
                    default: begin
                        twe_d = 1'b1;
                        if ({1'b0, idx_q} < cnt_q) begin
                            to_d = idx_entry;
                        end else begin
                            to_d    = '0;
                            set_unf = 1'b1;
                        end
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase
        if (push) begin
            if (!full || WRAP) begin
                wr_en   = 1'b1;
                wr_addr = wp_q;
                wr_val  = push_val;
            end
            if (full) begin
                set_ovf = 1'b1;
            end
        end
    end

    // Pointer/occupancy and sticky-flag updates; a fresh error beats err_clr.
    always_comb begin
        wp_d  = wp_q;
        cnt_d = cnt_q;
        if (push && (!full || WRAP)) begin
            wp_d = wp_q + RPW'(1);
            if (!full) begin
                cnt_d = cnt_q + (RPW+1)'(1);
            end
        end else if (pop) begin
            wp_d  = wp_q - RPW'(1);
            cnt_d = cnt_q - (RPW+1)'(1);
        end
        ovf_d = set_ovf || (ovf_q && !bus.err_clr);
        unf_d = set_unf || (unf_q && !bus.err_clr);
    end

    // FSM state register; holds its phase while the unit is disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else if (bus.br_en) begin
            state_q <= state_d;
        end
    end

    // Operand latches, stack pointers, flags and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q   <= OP_NOP;
            p_q    <= '0;
            t_q    <= '0;
            idx_q  <= '0;
            hi_q   <= '0;
            wp_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            done_q <= 1'b0;
            psel_q <= 1'b0;
            twe_q  <= 1'b0;
            tgt_q  <= '0;
            to_q   <= '0;
        end else if (bus.br_en) begin
            if (accept) begin
                op_q  <= op_in;
                p_q   <= bus.p;
                t_q   <= bus.t;
                idx_q <= bus.idx;
                hi_q  <= bus.data;
            end
            wp_q   <= wp_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            done_q <= done_d;
            psel_q <= psel_d;
            twe_q  <= twe_d;
            tgt_q  <= tgt_d;
            to_q   <= to_d;
        end else begin
            done_q <= 1'b0;
            psel_q <= 1'b0;
            twe_q  <= 1'b0;
        end
    end

    // Stack storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (bus.br_en && wr_en) begin
            mem[wr_addr] <= wr_val;
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = done_q && bus.br_en;
    assign bus.br_psel = psel_q && bus.br_en;
    assign bus.t_we    = twe_q && bus.br_en;
    assign bus.br_p_o  = tgt_q;
    assign bus.t_o     = to_q;
    assign bus.rs_cnt  = cnt_q;
    assign bus.ovf     = ovf_q;
    assign bus.unf     = unf_q;
endmodule

// File: tb/tb_ej32_rs_branch.sv
// tb_ej32_rs_branch: scoreboard bench for ej32_rs_branch.
// A queue-based return-stack model predicts each op's response when it is issued;
// a monitor compares it whenever the unit pulses done. Honours EJ32_RS_WRAP_EN.
module tb_ej32_rs_branch;
    localparam int DEPTH = 32;
    localparam int DSZ   = 32;
    localparam int ASZ   = 17;
    localparam int RPW   = $clog2(DEPTH);
`ifdef EJ32_RS_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef struct {
        bit             psel;
        logic [ASZ-1:0] tgt;
        bit             twe;
        logic [DSZ-1:0] to;
        int             cnt;
        bit             ovf;
        bit             unf;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    resp_t exp_q[$];
    logic [DSZ-1:0] st[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;
    int compared = 0;
    int mismatched = 0;

    ej32_rs_branch_if #(.DEPTH(DEPTH), .DSZ(DSZ), .ASZ(ASZ)) bus ();

    ej32_rs_branch #(.DEPTH(DEPTH), .DSZ(DSZ), .ASZ(ASZ)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference model push: full stack either drops the value or evicts the oldest.
    task automatic model_push(input logic [DSZ-1:0] v);
        if (st.size() == DEPTH) begin
            m_ovf = 1'b1;
            if (WRAP) begin
                void'(st.pop_back());
                st.push_front(v);
            end
        end else begin
            st.push_front(v);
        end
    endtask

    // Reference model of one op; the predicted response goes to the scoreboard.
    task automatic model_op(input int op, input logic [ASZ-1:0] p, input logic [DSZ-1:0] t,
                            input int idx, input logic [7:0] hi, input logic [7:0] lo);
        resp_t r;
        logic [15:0] tgt16;
        logic [DSZ-1:0] v;
        bit z, lt, take;
        r = '{psel: 1'b0, tgt: '0, twe: 1'b0, to: '0, cnt: 0, ovf: 1'b0, unf: 1'b0};
        tgt16 = {hi, lo};
        z = (t == 0);
        lt = t[DSZ-1];
        take = 1'b0;
        case (op)
            1: take = 1'b1;
            2: take = z;
            3: take = !z;
            4: take = lt;
            5: take = !lt;
            6: take = !z && !lt;
            7: take = z || lt;
            8: begin
                model_push(DSZ'((int'(p) + 2) % (1 << ASZ)));
                take = 1'b1;
            end
            9: begin
                if (st.size() == 0) m_unf = 1'b1;
                else begin
                    v = st.pop_front();
                    r.psel = 1'b1;
                    r.tgt = v[ASZ-1:0];
                end
            end
            10: begin
                if (st.size() == 0) m_unf = 1'b1;
                else if (st[0] == 0) void'(st.pop_front());
                else begin
                    st[0] = st[0] - 1;
                    take = 1'b1;
                end
            end
            11: model_push(t);
            12: begin
                if (st.size() == 0) m_unf = 1'b1;
                else begin
                    r.twe = 1'b1;
                    r.to = st.pop_front();
                end
            end
            13: begin
                if (st.size() == 0) m_unf = 1'b1;
                else begin
                    r.twe = 1'b1;
                    r.to = st[0];
                end
            end
            14: begin
                r.twe = 1'b1;
                if (idx < st.size()) r.to = st[idx];
                else begin
                    r.to = '0;
                    m_unf = 1'b1;
                end
            end
            15: begin
                if (idx < st.size()) st[idx] = t;
                else m_unf = 1'b1;
            end
            default: ;
        endcase
        if (take) begin
            r.psel = 1'b1;
            r.tgt = ASZ'(tgt16);
        end
        r.cnt = st.size();
        r.ovf = m_ovf;
        r.unf = m_unf;
        exp_q.push_back(r);
    endtask

    // Bounded wait until the unit can accept again.
    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.busy) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL idle_timeout: busy=%0b after %0d cycles, required 0", bus.busy, n);
        end
    endtask

    // Issue one op: high byte on the accept cycle, low byte on the next.
    task automatic apply_stimulus(input int op, input logic [ASZ-1:0] p, input logic [DSZ-1:0] t,
                                  input int idx, input logic [7:0] hi, input logic [7:0] lo);
        wait_idle();
        model_op(op, p, t, idx, hi, lo);
        bus.op_vld = 1'b1;
        bus.op = 4'(op);
        bus.p = p;
        bus.t = t;
        bus.idx = RPW'(idx);
        bus.data = hi;
        @(posedge clk);
        #1;
        bus.op_vld = 1'b0;
        bus.data = lo;
    endtask

    // Compare the oldest predicted response against what the unit presents.
    task automatic check_output();
        resp_t e;
        bit ok;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpected_done: done=1 with no op outstanding, required 0");
            return;
        end
        e = exp_q.pop_front();
        ok = (bus.br_psel == e.psel) && (!e.psel || bus.br_p_o == e.tgt) &&
             (bus.t_we == e.twe) && (!e.twe || bus.t_o == e.to) &&
             (int'(bus.rs_cnt) == e.cnt) && (bus.ovf == e.ovf) && (bus.unf == e.unf);
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL response: got psel=%0b p=%h twe=%0b t_o=%h cnt=%0d ovf=%0b unf=%0b, required psel=%0b p=%h twe=%0b t_o=%h cnt=%0d ovf=%0b unf=%0b",
                     bus.br_psel, bus.br_p_o, bus.t_we, bus.t_o, bus.rs_cnt, bus.ovf, bus.unf,
                     e.psel, e.tgt, e.twe, e.to, e.cnt, e.ovf, e.unf);
        end
    endtask

    // Monitor: score every done pulse and catch pulses that arrive without done.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.done) begin
                check_output();
            end else if (bus.br_psel || bus.t_we) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL stray_pulse: br_psel=%0b t_we=%0b without done, required 0", bus.br_psel, bus.t_we);
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        logic [DSZ-1:0] rt;
        bus.br_en = 1'b1;
        bus.op_vld = 1'b0;
        bus.op = '0;
        bus.p = '0;
        bus.data = '0;
        bus.t = '0;
        bus.idx = '0;
        bus.err_clr = 1'b0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (bus.busy || bus.done || bus.br_psel || bus.t_we || bus.rs_cnt != 0 ||
            bus.ovf || bus.unf || bus.br_p_o != 0 || bus.t_o != 0) begin
            mismatched++;
            $display("[TB] FAIL reset_state: busy=%0b done=%0b psel=%0b twe=%0b cnt=%0d ovf=%0b unf=%0b p=%h t_o=%h, required all 0",
                     bus.busy, bus.done, bus.br_psel, bus.t_we, bus.rs_cnt, bus.ovf, bus.unf, bus.br_p_o, bus.t_o);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed: call/ret, if, next, fill, empty pops");
        apply_stimulus(8, 17'h00100, '0, 0, 8'h01, 8'h23);
        apply_stimulus(9, 17'h00123, '0, 0, 8'h00, 8'h00);
        apply_stimulus(2, 17'h00200, '0, 0, 8'h00, 8'h40);
        apply_stimulus(2, 17'h00200, 32'd5, 0, 8'h00, 8'h40);
        for (int k = 4; k <= 7; k++) begin
            apply_stimulus(k, '0, 32'hFFFF_FFFF, 0, 8'h12, 8'h34);
            apply_stimulus(k, '0, 32'd0, 0, 8'h56, 8'h78);
        end
        apply_stimulus(11, '0, 32'd2, 0, 8'h00, 8'h00);
        for (int k = 0; k < 3; k++) apply_stimulus(10, '0, '0, 0, 8'h00, 8'h40);
        for (int k = 1; k <= 33; k++) apply_stimulus(11, '0, DSZ'(k), 0, 8'h00, 8'h00);
        apply_stimulus(14, '0, '0, 31, 8'h00, 8'h00);
        apply_stimulus(12, '0, '0, 0, 8'h00, 8'h00);
        apply_stimulus(14, '0, '0, 31, 8'h00, 8'h00);
        apply_stimulus(15, '0, 32'hABCD, 3, 8'h00, 8'h00);
        apply_stimulus(14, '0, '0, 3, 8'h00, 8'h00);
        for (int k = 0; k < 33; k++) apply_stimulus(12, '0, '0, 0, 8'h00, 8'h00);
        apply_stimulus(13, '0, '0, 0, 8'h00, 8'h00);
        apply_stimulus(9, '0, '0, 0, 8'h00, 8'h00);

        $display("[TB] directed: err_clr");
        wait_idle();
        compared++;
        if (bus.unf != 1'b1) begin
            mismatched++;
            $display("[TB] FAIL unf_sticky: unf=%0b, required 1", bus.unf);
        end
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        compared++;
        if (bus.unf != 1'b0 || bus.ovf != 1'b0) begin
            mismatched++;
            $display("[TB] FAIL err_clr: unf=%0b ovf=%0b, required 0 0", bus.unf, bus.ovf);
        end

        $display("[TB] directed: br_en stall in low-byte phase");
        wait_idle();
        model_op(1, '0, '0, 0, 8'h03, 8'h21);
        bus.op_vld = 1'b1;
        bus.op = 4'd1;
        bus.data = 8'h03;
        @(posedge clk);
        #1;
        bus.op_vld = 1'b0;
        bus.br_en = 1'b0;
        bus.data = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            compared++;
            if (bus.busy != 1'b1 || bus.done != 1'b0) begin
                mismatched++;
                $display("[TB] FAIL br_en_hold: busy=%0b done=%0b, required 1 0", bus.busy, bus.done);
            end
            @(posedge clk);
            #1;
        end
        bus.br_en = 1'b1;
        bus.data = 8'h21;
        @(posedge clk);
        #1;

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            int op;
            op = $urandom_range(0, 15);
            if (i < 150 && $urandom_range(0, 2) == 0) op = 11;
            case ($urandom_range(0, 3))
                0: rt = '0;
                1: rt = DSZ'($urandom_range(1, 9));
                2: begin
                    rt = DSZ'($urandom);
                    rt[DSZ-1] = 1'b1;
                end
                default: rt = DSZ'($urandom);
            endcase
            apply_stimulus(op, ASZ'($urandom), rt, $urandom_range(0, DEPTH - 1),
                           8'($urandom), 8'($urandom));
        end

        $display("[TB] directed: reset during low-byte phase");
        for (int k = 0; k < 3; k++) apply_stimulus(11, '0, DSZ'(k + 7), 0, 8'h00, 8'h00);
        wait_idle();
        bus.op_vld = 1'b1;
        bus.op = 4'd1;
        bus.data = 8'h05;
        @(posedge clk);
        #1;
        bus.op_vld = 1'b0;
        bus.data = 8'h55;
        #2 rst = 1'b0;
        #1;
        compared++;
        if (bus.busy || bus.br_psel || bus.rs_cnt != 0 || bus.done) begin
            mismatched++;
            $display("[TB] FAIL reset_abort: busy=%0b psel=%0b cnt=%0d done=%0b, required 0 0 0 0",
                     bus.busy, bus.br_psel, bus.rs_cnt, bus.done);
        end
        st.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(9, '0, '0, 0, 8'h00, 8'h00);
        apply_stimulus(8, 17'h1FFFF, '0, 0, 8'hFF, 8'hFF);
        apply_stimulus(9, '0, '0, 0, 8'h00, 8'h00);

        wait_idle();
        repeat (2) @(negedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL pending: %0d responses never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
